// File: rtl/prefetch_unit.sv
// Instruction fetch unit: PC sequencing, 1-cycle imem reads, QDEPTH prefetch FIFO.
// Optional RUN-cycle counter on cycle_count when FETCH_CYCLE_CNT_EN is defined.
module prefetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter int QDEPTH  = 4
) (
  input  logic               f_clk,
  input  logic               f_rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic               halt,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  input  logic               dec_ready,
  output logic               running,
  output logic [31:0]        cycle_count
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     req_pc_q;
  logic                inflight_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [INSTR_W-1:0]  instr_q [QDEPTH];
  logic [PC_W-1:0]     ipc_q [QDEPTH];
  logic [CW:0]         occ;
  logic                flush, push, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outstanding read counts against space so the queue can never overflow
  assign occ   = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
  assign flush = start | (redirect & (state_q != S_IDLE));
  assign push  = inflight_q & ~flush;
  assign pop   = dec_valid & dec_ready & ~flush;

  assign imem_rd = (state_q == S_RUN) & ~halt & ~start & ~redirect
                 & (occ < (CW+1)'(QDEPTH));
  assign imem_addr = pc_q;
  assign running   = (state_q != S_IDLE);

  assign dec_valid = (cnt_q != '0);
  assign dec_instr = dec_valid ? instr_q[rptr_q] : '0;
  assign dec_pc    = dec_valid ? ipc_q[rptr_q] : '0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (start) begin
      state_d = S_RUN;
      pc_d    = start_addr;
    end else begin
      unique case (state_q)
        S_RUN:   if (!redirect && halt) state_d = S_HALT;
        S_HALT:  if (!redirect && !halt) state_d = S_RUN;
        default: state_d = state_q;
      endcase
      if (flush) pc_d = redirect_target;
      else if (imem_rd) pc_d = pc_q + PC_W'(1);
    end
    if (flush) begin
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = inc(wptr_q);
      if (pop) rptr_d = inc(rptr_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge f_clk or negedge f_rst_n) begin
    if (!f_rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= imem_rd;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      if (imem_rd) req_pc_q <= pc_q;
      if (push) begin
        instr_q[wptr_q] <= imem_data;
        ipc_q[wptr_q]   <= req_pc_q;
      end
    end
  end

`ifdef FETCH_CYCLE_CNT_EN
  logic [31:0] cc_q;

  always_ff @(posedge f_clk or negedge f_rst_n) begin
    if (!f_rst_n) cc_q <= '0;
    else if (start) cc_q <= '0;
    else if (state_q == S_RUN) cc_q <= cc_q + 32'd1;
  end

  assign cycle_count = cc_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a PC/instruction scoreboard.
// Expected dec_* stream is preloaded on start/redirect and popped on accept.
module tb_prefetch_unit;

  logic       f_clk = 1'b0;
  logic       f_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_addr = '0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_target = '0;
  logic       halt = 1'b0;
  logic       imem_rd;
  logic [7:0] imem_addr;
  logic [8:0] imem_data = '0;
  logic       dec_valid;
  logic [8:0] dec_instr;
  logic [7:0] dec_pc;
  logic       dec_ready = 1'b0;
  logic       running;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic [7:0] last_req = '0;
  logic [7:0] sb [$];

`ifdef FETCH_CYCLE_CNT_EN
  localparam logic [31:0] CC3 = 32'd2;
`else
  localparam logic [31:0] CC3 = 32'd0;
`endif

  prefetch_unit dut (
    .f_clk(f_clk),
    .f_rst_n(f_rst_n),
    .start(start),
    .start_addr(start_addr),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .halt(halt),
    .imem_rd(imem_rd),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .dec_valid(dec_valid),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc),
    .dec_ready(dec_ready),
    .running(running),
    .cycle_count(cycle_count)
  );

  always #5 f_clk = ~f_clk;

  function automatic logic [8:0] rom(input logic [7:0] a);
    return {^a, a ^ 8'h5A};
  endfunction

  always @(posedge f_clk)
    imem_data <= imem_rd ? rom(imem_addr) : 9'h155;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [7:0] a);
    logic [7:0] v;
    v = a;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      sb.push_back(v);
      v = v + 8'd1;
    end
  endtask

  task automatic tick();
    @(posedge f_clk);
    #1;
  endtask

  always @(negedge f_clk) begin
    if (f_rst_n) begin
      if (imem_rd) last_req = imem_addr;
      if (dec_valid && dec_ready && !start && !redirect) begin
        logic [7:0] e;
        chk("sb_avail", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("dec_pc", 32'(dec_pc), 32'(e));
          chk("dec_instr", 32'(dec_instr), 32'(rom(e)));
          pops++;
        end
      end
    end
  end

  initial begin
    logic [7:0]  nxt;
    logic [31:0] cc1;
    int reqs, p0;
    bit found;

    // reset values
    #12;
    chk("rst_imem_rd", 32'(imem_rd), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_dec_pc", 32'(dec_pc), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_cc", cycle_count, 0);
    f_rst_n = 1'b1;
    tick();

    // start at 0x10, streaming
    dec_ready = 1'b1;
    start = 1'b1;
    start_addr = 8'h10;
    sb_load(8'h10);
    @(negedge f_clk);
    chk("t1_rd_during_start", 32'(imem_rd), 0);
    tick();
    start = 1'b0;
    @(negedge f_clk);
    chk("t1_c1_rd", 32'(imem_rd), 1);
    chk("t1_c1_addr", 32'(imem_addr), 32'h10);
    chk("t1_c1_running", 32'(running), 1);
    tick();
    @(negedge f_clk);
    chk("t1_c2_valid", 32'(dec_valid), 0);
    tick();
    @(negedge f_clk);
    chk("t1_c3_valid", 32'(dec_valid), 1);
    chk("t1_c3_pc", 32'(dec_pc), 32'h10);
    chk("t1_c3_cc", cycle_count, CC3);
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge f_clk);
      chk("t1_thru_valid", 32'(dec_valid), 1);
    end

    // backpressure: start at 0x20 with decode stalled
    tick();
    dec_ready = 1'b0;
    start = 1'b1;
    start_addr = 8'h20;
    sb_load(8'h20);
    tick();
    start = 1'b0;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge f_clk);
      if (imem_rd) begin
        chk("t2_req_addr", 32'(imem_addr), 32'h20 + 32'(reqs));
        reqs++;
      end
      tick();
    end
    chk("t2_req_count", reqs, 4);
    @(negedge f_clk);
    chk("t2_head_valid", 32'(dec_valid), 1);
    chk("t2_head_pc", 32'(dec_pc), 32'h20);
    tick();
    dec_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge f_clk);
      if (imem_rd) begin
        found = 1'b1;
        chk("t2_resume_addr", 32'(imem_addr), 32'h24);
      end
      tick();
    end
    chk("t2_resume_seen", 32'(found), 1);
    repeat (6) tick();

    // redirect with 3 queued entries and one read in flight
    dec_ready = 1'b0;
    start = 1'b1;
    start_addr = 8'h30;
    sb_load(8'h30);
    tick();
    start = 1'b0;
    repeat (4) tick();
    redirect = 1'b1;
    redirect_target = 8'h40;
    dec_ready = 1'b1;
    sb_load(8'h40);
    @(negedge f_clk);
    chk("t3_pre_valid", 32'(dec_valid), 1);
    chk("t3_pre_pc", 32'(dec_pc), 32'h30);
    chk("t3_pre_rd", 32'(imem_rd), 0);
    tick();
    redirect = 1'b0;
    @(negedge f_clk);
    chk("t3_r1_rd", 32'(imem_rd), 1);
    chk("t3_r1_addr", 32'(imem_addr), 32'h40);
    chk("t3_r1_valid", 32'(dec_valid), 0);
    tick();
    @(negedge f_clk);
    chk("t3_r2_valid", 32'(dec_valid), 0);
    tick();
    @(negedge f_clk);
    chk("t3_r3_valid", 32'(dec_valid), 1);
    chk("t3_r3_pc", 32'(dec_pc), 32'h40);
    repeat (3) tick();

    // halt for 5 cycles
    halt = 1'b1;
    nxt = last_req + 8'd1;
    cc1 = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge f_clk);
      chk("t4_halt_rd", 32'(imem_rd), 0);
      if (i == 1) cc1 = cycle_count;
      if (i == 4) begin
        chk("t4_drained", 32'(dec_valid), 0);
        chk("t4_cc_frozen", cycle_count, cc1);
        chk("t4_running", 32'(running), 1);
      end
      tick();
    end
    halt = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge f_clk);
      if (imem_rd) begin
        found = 1'b1;
        chk("t4_resume_addr", 32'(imem_addr), 32'(nxt));
      end
      tick();
    end
    chk("t4_resume_seen", 32'(found), 1);
    repeat (5) tick();

    // PC wrap from 0xFE
    p0 = pops;
    start = 1'b1;
    start_addr = 8'hFE;
    sb_load(8'hFE);
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("t5_wrap_pops", 32'((pops - p0) >= 4), 1);

    // asynchronous reset mid-stream
    #2;
    f_rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_rd", 32'(imem_rd), 0);
    chk("t6_addr", 32'(imem_addr), 0);
    chk("t6_valid", 32'(dec_valid), 0);
    chk("t6_instr", 32'(dec_instr), 0);
    chk("t6_pc", 32'(dec_pc), 0);
    chk("t6_running", 32'(running), 0);
    chk("t6_cc", cycle_count, 0);
    tick();
    tick();
    f_rst_n = 1'b1;
    tick();
    start = 1'b1;
    start_addr = 8'h05;
    sb_load(8'h05);
    tick();
    start = 1'b0;
    @(negedge f_clk);
    chk("t6_c1_addr", 32'(imem_addr), 32'h05);
    tick();
    @(negedge f_clk);
    chk("t6_c2_valid", 32'(dec_valid), 0);
    tick();
    @(negedge f_clk);
    chk("t6_c3_valid", 32'(dec_valid), 1);
    chk("t6_c3_pc", 32'(dec_pc), 32'h05);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
